// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush control for the 5-stage core, plus tracking of in-flight
// instruction fetches so that beats returning after a flush are discarded.
module pipe_ctrl #(
  parameter int OUTS_W   = 2,
  parameter int MAX_OUTS = 2
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_exe,
  input  logic              stallreq_mem,
  input  logic              exc_valid,
  input  logic              inst_req,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              inst_discard,
  output logic              inst_req_allow,
  output logic [OUTS_W-1:0] outs_cnt
);

  // state | meaning
  // RUN   | no stale fetches pending; disc_cnt == 0
  // DRAIN | disc_cnt > 0 stale beats still to arrive; they are discarded
  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  localparam int                SUM_W   = OUTS_W + 2;
  localparam logic [SUM_W-1:0]  MAX_S   = SUM_W'(MAX_OUTS);
  localparam logic [SUM_W-1:0]  CNT_TOP = SUM_W'((1 << OUTS_W) - 1);
  localparam logic [OUTS_W-1:0] MAX_C   = OUTS_W'(MAX_OUTS);

  state_t            state, state_nxt;
  logic [OUTS_W-1:0] disc_cnt, disc_nxt, outs_nxt;
  logic [SUM_W-1:0]  outs_sum, disc_sum;
  logic              flush_raw, acc, dec;

  assign flush_raw = exc_valid & ~stallreq_mem;
  assign acc       = inst_req & inst_addr_ok;
  // A data beat with nothing outstanding is a protocol error and is ignored.
  assign dec       = inst_data_ok & (outs_cnt != '0);

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state    <= RUN;
      outs_cnt <= '0;
      disc_cnt <= '0;
    end else begin
      state    <= state_nxt;
      outs_cnt <= outs_nxt;
      disc_cnt <= disc_nxt;
    end
  end

  always_comb begin
    outs_sum = SUM_W'(outs_cnt) + SUM_W'(acc) - SUM_W'(dec);
    outs_nxt = (outs_sum > CNT_TOP) ? CNT_TOP[OUTS_W-1:0] : outs_sum[OUTS_W-1:0];

    // Stale beats after a flush: everything outstanding plus what was already
    // pending, less the beat consumed this cycle.
    disc_sum = SUM_W'(outs_cnt) - SUM_W'(dec & (state == RUN))
             + SUM_W'(disc_cnt) - SUM_W'(inst_data_ok & (state == DRAIN));

    disc_nxt = disc_cnt;
    if (flush_raw) begin
      disc_nxt = (disc_sum > MAX_S) ? MAX_C : disc_sum[OUTS_W-1:0];
    end else if ((state == DRAIN) && inst_data_ok && (disc_cnt != '0)) begin
      disc_nxt = disc_cnt - OUTS_W'(1);
    end

    state_nxt = (disc_nxt != '0) ? DRAIN : RUN;
  end

  always_comb begin
    stall          = 6'b000000;
    flush          = 1'b0;
    inst_discard   = 1'b0;
    inst_req_allow = 1'b0;
    if (cpu_rst_n) begin
      flush          = flush_raw;
      inst_discard   = (state == DRAIN) & inst_data_ok;
      inst_req_allow = (SUM_W'(outs_cnt) < MAX_S) | inst_data_ok;
      if (!flush_raw) begin
        if (stallreq_mem)                       stall = 6'b011111;
        else if (stallreq_exe)                  stall = 6'b001111;
        else if (stallreq_id)                   stall = 6'b000111;
        else if (stallreq_if && state == RUN)   stall = 6'b000011;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then randomized traffic,
// expected outputs pushed by the driver and checked by an independent monitor.
module tb_pipe_ctrl;

  logic       clk;
  logic       rst_n, sif, sid, sexe, smem, exc, req, aok, dok;
  logic [5:0] stall;
  logic       flush, discard, allow;
  logic [1:0] outs;

  pipe_ctrl #(.OUTS_W(2), .MAX_OUTS(2)) dut (
    .cpu_clk_50M   (clk),
    .cpu_rst_n     (rst_n),
    .stallreq_if   (sif),
    .stallreq_id   (sid),
    .stallreq_exe  (sexe),
    .stallreq_mem  (smem),
    .exc_valid     (exc),
    .inst_req      (req),
    .inst_addr_ok  (aok),
    .inst_data_ok  (dok),
    .stall         (stall),
    .flush         (flush),
    .inst_discard  (discard),
    .inst_req_allow(allow),
    .outs_cnt      (outs)
  );

  typedef struct {
    logic [5:0] stall;
    logic       flush;
    logic       disc;
    logic       allow;
    logic [1:0] outs;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: fetches in flight and stale beats still to be discarded.
  int m_outs = 0;
  int m_disc = 0;
  localparam int MAXO = 2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  task automatic step(input bit r, input bit i_if, input bit i_id, input bit i_exe,
                      input bit i_mem, input bit i_exc, input bit i_req,
                      input bit i_aok, input bit i_dok);
    exp_t e;
    int   lvl, d;
    bit   draining, fl;
    @(negedge clk);
    #1;
    rst_n = r; sif = i_if; sid = i_id; sexe = i_exe; smem = i_mem;
    exc = i_exc; req = i_req; aok = i_aok; dok = i_dok;

    draining = (m_disc > 0);
    fl = r && i_exc && !i_mem;
    // Highest stalling stage k holds stages 0..k.
    lvl = i_mem ? 4 : i_exe ? 3 : i_id ? 2 : (i_if && !draining) ? 1 : 0;
    e.stall = (!r || fl || lvl == 0) ? 6'd0 : 6'((1 << (lvl + 1)) - 1);
    e.flush = fl;
    e.disc  = r && draining && i_dok;
    e.allow = r && ((m_outs < MAXO) || i_dok);
    e.outs  = 2'(m_outs);
    q.push_back(e);

    if (!r) begin
      m_outs = 0;
      m_disc = 0;
    end else begin
      if (fl) begin
        d = m_outs - ((i_dok && !draining && m_outs > 0) ? 1 : 0)
          + m_disc - ((i_dok && draining) ? 1 : 0);
        m_disc = (d > MAXO) ? MAXO : d;
      end else if (draining && i_dok) begin
        m_disc = m_disc - 1;
      end
      m_outs = m_outs + ((i_req && i_aok) ? 1 : 0) - ((i_dok && m_outs > 0) ? 1 : 0);
      if (m_outs > 3) m_outs = 3;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall",          int'(stall),   int'(e.stall));
        chk("flush",          int'(flush),   int'(e.flush));
        chk("inst_discard",   int'(discard), int'(e.disc));
        chk("inst_req_allow", int'(allow),   int'(e.allow));
        chk("outs_cnt",       int'(outs),    int'(e.outs));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit r, d, a, rq;
    rst_n = 1'b0; sif = 0; sid = 0; sexe = 0; smem = 0;
    exc = 0; req = 0; aok = 0; dok = 0;

    // args: rst_n, if, id, exe, mem, exc, req, addr_ok, data_ok
    step(0,0,0,0,0,0,0,0,0);
    step(0,1,1,1,1,1,1,1,1);
    // load-use stall for two cycles, then release
    step(1,0,1,0,0,0,0,0,0);
    step(1,0,1,0,0,0,0,0,0);
    step(1,0,0,0,0,0,0,0,0);
    // mem outranks id, then id alone
    step(1,0,1,0,1,0,0,0,0);
    step(1,0,1,0,0,0,0,0,0);
    step(1,1,0,0,0,0,0,0,0);
    step(1,0,0,1,0,0,0,0,0);
    // exception deferred behind a stalled MEM, fires when MEM releases
    step(1,0,0,0,1,1,0,0,0);
    step(1,0,0,0,1,1,0,0,0);
    step(1,0,0,0,1,1,0,0,0);
    step(1,1,1,1,0,1,0,0,0);
    step(1,0,0,0,0,0,0,0,0);
    // two fetches in flight, flush, two discarded beats, then a beat with none pending
    step(1,0,0,0,0,0,1,1,0);
    step(1,0,0,0,0,0,1,1,0);
    step(1,0,0,0,0,1,0,0,0);
    step(1,1,0,0,0,0,0,0,0);
    step(1,0,0,0,0,0,0,0,1);
    step(1,1,0,0,0,0,0,0,1);
    step(1,1,0,0,0,0,0,0,1);
    step(1,0,0,0,0,0,0,0,0);
    // allow drops at MAX_OUTS, returns with data_ok; accept+return keeps count
    step(1,0,0,0,0,0,1,1,0);
    step(1,0,0,0,0,0,1,1,0);
    step(1,0,0,0,0,0,0,0,0);
    step(1,0,0,0,0,0,1,1,1);
    step(1,0,0,0,0,0,0,0,1);
    step(1,0,0,0,0,0,0,0,1);
    // flush with a data beat in RUN: beat delivered, remainder drained
    step(1,0,0,0,0,0,1,1,0);
    step(1,0,0,0,0,0,1,1,0);
    step(1,0,0,0,0,1,0,0,1);
    step(1,0,0,0,0,0,0,0,1);
    step(1,0,0,0,0,0,0,0,1);
    // reset while draining one stale beat
    step(1,0,0,0,0,0,1,1,0);
    step(1,0,0,0,0,1,0,0,0);
    step(0,1,1,0,0,1,1,1,1);
    step(0,0,0,0,0,0,0,0,0);
    step(1,1,0,0,0,0,0,0,1);
    step(1,1,0,0,0,0,0,0,0);

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) >= 2);
      d  = (m_outs > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 5);
      a  = ($urandom_range(0, 99) < 60);
      rq = r && ((m_outs < MAXO) || d) && ($urandom_range(0, 99) < 70);
      step(r,
           ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 12), rq, a, d);
    end

    @(negedge clk);
    #5;
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
